// File: rtl/bongo_controller_port_pkg.sv
// Shared constants and report packing for the bongo drum controller port.
// The report carries the four debounced levels in the low nibble and the sticky hits in the high nibble.
package bongo_controller_port_pkg;

    localparam logic [15:0] BONGO_PORT_ADDR = 16'h4016;
    localparam int          DRUM_COUNT      = 4;
    localparam int          RPT_LEVEL_LSB   = 0;
    localparam int          RPT_HIT_LSB     = 4;

    function automatic logic [7:0] build_report(input logic [DRUM_COUNT-1:0] level,
                                                input logic [DRUM_COUNT-1:0] hit);
        logic [7:0] rpt;
        rpt = '0;
        for (int i = 0; i < DRUM_COUNT; i++) begin
            rpt[RPT_LEVEL_LSB + i] = level[i];
            rpt[RPT_HIT_LSB + i]   = hit[i];
        end
        return rpt;
    endfunction

endpackage

// File: rtl/bongo_controller_port_if.sv
// CPU-side bus for the bongo port: single-cycle read/write strobes, no backpressure.
// Bus contract: write_cpu/read_cpu are one-cycle strobes qualified by addr_cpu; the responder never
// stalls, and read data appears on data_cpu_out exactly one cycle after read_cpu with data_cpu_oe high.
interface bongo_controller_port_if;
    logic [15:0] addr_cpu;
    logic        write_cpu;
    logic        read_cpu;
    logic [7:0]  data_cpu_in;
    logic [7:0]  data_cpu_out;
    logic        data_cpu_oe;

    modport master (
        output addr_cpu, write_cpu, read_cpu, data_cpu_in,
        input  data_cpu_out, data_cpu_oe
    );

    modport slave (
        input  addr_cpu, write_cpu, read_cpu, data_cpu_in,
        output data_cpu_out, data_cpu_oe
    );
endinterface

// File: rtl/bongo_controller_port_drum_debounce.sv
// One drum contact: multi-flop synchroniser followed by a saturating stability counter.
// Outputs the accepted level and a one-cycle pulse on the cycle the level rises.
module bongo_controller_port_drum_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk_cpu,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d    = '0;
        stable_d = stable_q;
        // Counter only advances while the level disagrees; the >= compare keeps it from wrapping.
        if (sync_lvl != stable_q) begin
            if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_lvl;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
endmodule

// File: rtl/bongo_controller_port.sv
// Bongo controller joypad-style port: debounced drum levels, sticky hits, strobe latch and
// a serial shift register read one bit per CPU access.
module bongo_controller_port
    import bongo_controller_port_pkg::*;
#(
    parameter logic [15:0] PORT_ADDR       = BONGO_PORT_ADDR,
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic [1:0]               right,
    input  logic [1:0]               left,
    bongo_controller_port_if.slave   bus,
    output logic [3:0]               drum_state
);
    logic [DRUM_COUNT-1:0] raw, level, rise;
    logic [DRUM_COUNT-1:0] hit_q, hit_d;
    logic                  strobe_q, strobe_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            out_q, out_d;
    logic                  oe_q, oe_d;
    logic                  wr_hit, rd_hit, latch, read_bit;
    logic [7:0]            report;
    logic                  unused_data_bits;

    assign raw              = {left, right};
    assign unused_data_bits = ^bus.data_cpu_in[7:1];

    for (genvar i = 0; i < DRUM_COUNT; i++) begin : g_drum
        bongo_controller_port_drum_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_cpu (clk_cpu),
            .rst     (rst),
            .raw     (raw[i]),
            .stable  (level[i]),
            .rise    (rise[i])
        );
    end

    always_comb begin
        wr_hit   = bus.write_cpu && (bus.addr_cpu == PORT_ADDR);
        rd_hit   = bus.read_cpu  && (bus.addr_cpu == PORT_ADDR);
        latch    = wr_hit && strobe_q && !bus.data_cpu_in[0];
        // A rise landing on the latch cycle goes into the report and is consumed by the clear.
        report   = build_report(level, hit_q | rise);
        read_bit = strobe_q ? level[0] : shift_q[0];

        strobe_d = wr_hit ? bus.data_cpu_in[0] : strobe_q;
        hit_d    = latch ? '0 : (hit_q | rise);

        shift_d = shift_q;
        if (strobe_q) begin
            shift_d = report;
        end else if (rd_hit) begin
            shift_d = {1'b1, shift_q[7:1]};
        end

        oe_d  = rd_hit;
        out_d = rd_hit ? {7'b0, read_bit} : 8'h00;
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            hit_q    <= '0;
            strobe_q <= 1'b0;
            shift_q  <= 8'h00;
            out_q    <= 8'h00;
            oe_q     <= 1'b0;
        end else begin
            hit_q    <= hit_d;
            strobe_q <= strobe_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
        end
    end

    assign bus.data_cpu_out = out_q;
    assign bus.data_cpu_oe  = oe_q;
    assign drum_state       = level;
endmodule

// File: tb/tb_bongo_controller_port.sv
// Directed bench for the bongo controller port with a short debounce window.
module tb_bongo_controller_port;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic       clk_cpu;
  logic       rst;
  logic [1:0] right;
  logic [1:0] left;
  logic [3:0] drum_state;
  int         n_pass;
  int         n_total;

  bongo_controller_port_if bus();

  bongo_controller_port #(
    .PORT_ADDR       (16'h4016),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk_cpu    (clk_cpu),
    .rst        (rst),
    .right      (right),
    .left       (left),
    .bus        (bus),
    .drum_state (drum_state)
  );

  // clock / reset
  initial begin
    clk_cpu = 1'b0;
    forever #5 clk_cpu = ~clk_cpu;
  end

  task automatic do_reset();
    @(negedge clk_cpu);
    rst = 1'b1;
    repeat (2) @(negedge clk_cpu);
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_cpu);
    bus.addr_cpu    = a;
    bus.data_cpu_in = d;
    bus.write_cpu   = 1'b1;
    @(negedge clk_cpu);
    bus.write_cpu   = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk_cpu);
    bus.addr_cpu = a;
    bus.read_cpu = 1'b1;
    @(negedge clk_cpu);
    bus.read_cpu = 1'b0;
    d  = bus.data_cpu_out;
    oe = bus.data_cpu_oe;
  endtask

  task automatic hold_inputs(input logic [1:0] r, input logic [1:0] l, input int cycles);
    @(negedge clk_cpu);
    right = r;
    left  = l;
    repeat (cycles) @(negedge clk_cpu);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_cpu);
    n_total++;
    if (bus.data_cpu_out !== 8'h00 || bus.data_cpu_oe !== 1'b0 || drum_state !== 4'h0)
      $display("FAIL reset_outputs: out=%h oe=%b drum=%b required out=00 oe=0 drum=0000",
               bus.data_cpu_out, bus.data_cpu_oe, drum_state);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    @(negedge clk_cpu);
    right = 2'b01;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_cpu);
      if (lat == 0 && drum_state[0]) lat = k;
    end
    n_total++;
    if (lat !== SYNC + DEB)
      $display("FAIL debounce_latency: got %0d cycles (0 = never) required %0d", lat, SYNC + DEB);
    else n_pass++;
    n_total++;
    if (drum_state !== 4'b0001)
      $display("FAIL drum_state_held: got %b required 0001", drum_state);
    else n_pass++;
    right = 2'b00;
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic       oe;
    logic       seen;
    do_reset();
    @(negedge clk_cpu);
    right = 2'b01;
    repeat (3) @(negedge clk_cpu);
    right = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_cpu);
      if (drum_state !== 4'h0) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL glitch_level: drum_state went nonzero, required stay 0000");
    else n_pass++;
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int k = 0; k < 8; k++) cpu_read(16'h4016, d, oe);
    // Eighth read consumed all report bits; compare the hit[0] read separately below.
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int k = 0; k < 5; k++) cpu_read(16'h4016, d, oe);
    n_total++;
    if (d !== 8'h00 || oe !== 1'b1)
      $display("FAIL glitch_hit: read5 got %h oe=%b required 00 oe=1", d, oe);
    else n_pass++;
  endtask

  task automatic test_report_read();
    logic [7:0] d;
    logic       oe;
    logic [9:0] exp_bits;
    exp_bits = 10'b11_1001_1001;
    do_reset();
    hold_inputs(2'b01, 2'b10, 10);
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int k = 0; k < 10; k++) begin
      cpu_read(16'h4016, d, oe);
      n_total++;
      if (d !== {7'b0, exp_bits[k]} || oe !== 1'b1)
        $display("FAIL report_read%0d: got %h oe=%b required %h oe=1", k + 1, d, oe, {7'b0, exp_bits[k]});
      else n_pass++;
    end
    hold_inputs(2'b00, 2'b00, 8);
  endtask

  task automatic test_sticky_clear();
    logic [7:0] d;
    logic [7:0] got;
    logic       oe;
    do_reset();
    hold_inputs(2'b00, 2'b01, 8);
    hold_inputs(2'b00, 2'b00, 8);
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    got = 8'h00;
    for (int k = 0; k < 8; k++) begin
      cpu_read(16'h4016, d, oe);
      got[k] = d[0];
    end
    n_total++;
    if (got !== 8'h40) $display("FAIL sticky_first: report %h required 40", got);
    else n_pass++;
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    got = 8'hff;
    for (int k = 0; k < 8; k++) begin
      cpu_read(16'h4016, d, oe);
      got[k] = d[0];
    end
    n_total++;
    if (got !== 8'h00) $display("FAIL sticky_cleared: report %h required 00", got);
    else n_pass++;
  endtask

  task automatic test_strobe_live();
    logic [7:0] d;
    logic       oe;
    do_reset();
    hold_inputs(2'b01, 2'b00, 10);
    cpu_write(16'h4016, 8'h01);
    for (int k = 0; k < 3; k++) begin
      cpu_read(16'h4016, d, oe);
      n_total++;
      if (d !== 8'h01 || oe !== 1'b1)
        $display("FAIL strobe_live_read%0d: got %h oe=%b required 01 oe=1", k + 1, d, oe);
      else n_pass++;
      @(negedge clk_cpu);
      n_total++;
      if (bus.data_cpu_oe !== 1'b0 || bus.data_cpu_out !== 8'h00)
        $display("FAIL oe_one_cycle%0d: oe=%b out=%h required oe=0 out=00", k + 1,
                 bus.data_cpu_oe, bus.data_cpu_out);
      else n_pass++;
    end
    cpu_read(16'h4017, d, oe);
    n_total++;
    if (oe !== 1'b0 || d !== 8'h00)
      $display("FAIL other_addr: got %h oe=%b required 00 oe=0", d, oe);
    else n_pass++;
    cpu_write(16'h4016, 8'h00);
    hold_inputs(2'b00, 2'b00, 8);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       oe;
    do_reset();
    hold_inputs(2'b01, 2'b10, 10);
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    // Read and a redundant strobe-0 write in the same cycle: no re-latch, one shift.
    @(negedge clk_cpu);
    bus.addr_cpu    = 16'h4016;
    bus.data_cpu_in = 8'h00;
    bus.write_cpu   = 1'b1;
    bus.read_cpu    = 1'b1;
    @(negedge clk_cpu);
    bus.write_cpu   = 1'b0;
    bus.read_cpu    = 1'b0;
    n_total++;
    if (bus.data_cpu_out !== 8'h01 || bus.data_cpu_oe !== 1'b1)
      $display("FAIL rw_same_cycle: got %h oe=%b required 01 oe=1", bus.data_cpu_out, bus.data_cpu_oe);
    else n_pass++;
    cpu_read(16'h4016, d, oe);
    n_total++;
    if (d !== 8'h00) $display("FAIL after_rw_read2: got %h required 00", d);
    else n_pass++;
    cpu_read(16'h4016, d, oe);
    cpu_read(16'h4016, d, oe);
    n_total++;
    if (d !== 8'h01) $display("FAIL after_rw_read4: got %h required 01", d);
    else n_pass++;
    hold_inputs(2'b00, 2'b00, 8);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic       oe;
    do_reset();
    hold_inputs(2'b01, 2'b10, 10);
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int k = 0; k < 3; k++) cpu_read(16'h4016, d, oe);
    @(negedge clk_cpu);
    bus.addr_cpu = 16'h4016;
    bus.read_cpu = 1'b1;
    rst          = 1'b1;
    right        = 2'b00;
    left         = 2'b00;
    @(negedge clk_cpu);
    bus.read_cpu = 1'b0;
    n_total++;
    if (bus.data_cpu_oe !== 1'b0 || bus.data_cpu_out !== 8'h00 || drum_state !== 4'h0)
      $display("FAIL reset_mid_read: oe=%b out=%h drum=%b required oe=0 out=00 drum=0000",
               bus.data_cpu_oe, bus.data_cpu_out, drum_state);
    else n_pass++;
    rst = 1'b0;
    cpu_read(16'h4016, d, oe);
    n_total++;
    if (d !== 8'h00 || oe !== 1'b1)
      $display("FAIL read_after_reset: got %h oe=%b required 00 oe=1", d, oe);
    else n_pass++;
  endtask

  // main sequence and final report
  initial begin
    n_pass          = 0;
    n_total         = 0;
    rst             = 1'b1;
    right           = 2'b00;
    left            = 2'b00;
    bus.addr_cpu    = 16'h0000;
    bus.write_cpu   = 1'b0;
    bus.read_cpu    = 1'b0;
    bus.data_cpu_in = 8'h00;
    test_reset();
    test_latency();
    test_glitch();
    test_report_read();
    test_sticky_clear();
    test_strobe_live();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
